cpu_multicycle: RTL



---
 rtl/cpu_multicycle_if.sv | 22 ++
 rtl/cpu_multicycle.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_if.sv
// Unified instruction/data memory port. The core issues requests and the memory
// completes each one by raising mem_ready.
interface cpu_multicycle_if #(
   parameter int unsigned n = 16
);
   logic         mem_req;
   logic         mem_we;
   logic [n-1:0] mem_addr;
   logic [n-1:0] mem_wdata;
   logic [n-1:0] mem_rdata;
   logic         mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle MIPS-style core over one shared req/ready memory port. Adds HALT,
// sticky signed overflow and illegal-opcode detection.
module cpu_multicycle #(
   parameter int unsigned  n        = 16,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   cpu_multicycle_if.master mem,
   output logic [n-1:0]     pc,
   output logic             halted,
   output logic             overflow,
   output logic             illegal
);

   typedef enum logic [2:0] {
      StFetch, StDecode, StExec, StMem, StWb, StHalt
   } state_t;

   localparam logic [4:0] OpAdd  = 5'd0;
   localparam logic [4:0] OpSub  = 5'd1;
   localparam logic [4:0] OpAnd  = 5'd2;
   localparam logic [4:0] OpOr   = 5'd3;
   localparam logic [4:0] OpSlt  = 5'd4;
   localparam logic [4:0] OpAddi = 5'd5;
   localparam logic [4:0] OpLw   = 5'd6;
   localparam logic [4:0] OpSw   = 5'd7;
   localparam logic [4:0] OpBeq  = 5'd8;
   localparam logic [4:0] OpJ    = 5'd9;
   localparam logic [4:0] OpHalt = 5'd31;

   state_t       state_q, state_d;
   logic         run_q;
   logic [n-1:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
   logic [n-1:0] rf_q [8];
   logic         ovf_q, ill_q;

   logic [4:0]   op;
   logic [2:0]   rs, rt, rd, wb_dst;
   logic [n-1:0] imm, target, opnd_b, sum, diff, alu_res, wb_data;
   logic         alu_ovf, legal, is_rtype, use_imm;

   assign op       = ir_q[4:0];
   assign rs       = ir_q[7:5];
   assign rt       = ir_q[10:8];
   assign rd       = ir_q[13:11];
   assign imm      = {{(n-5){ir_q[15]}}, ir_q[15:11]};
   assign target   = {{(n-11){1'b0}}, ir_q[15:5]};
   assign legal    = (op <= OpJ) || (op == OpHalt);
   assign is_rtype = (op <= OpSlt);
   assign use_imm  = (op == OpAddi) || (op == OpLw) || (op == OpSw);
   assign wb_dst   = is_rtype ? rd : rt;
   assign wb_data  = (op == OpLw) ? mdr_q : alu_q;

   assign pc       = pc_q;
   assign halted   = (state_q == StHalt);
   assign overflow = ovf_q;
   assign illegal  = ill_q;

   always_comb begin
      opnd_b  = use_imm ? imm : b_q;
      sum     = a_q + opnd_b;
      diff    = a_q - b_q;
      alu_res = sum;
      alu_ovf = 1'b0;
      case (op)
         OpAdd, OpAddi: alu_ovf = (a_q[n-1] == opnd_b[n-1]) && (sum[n-1] != a_q[n-1]);
         OpSub: begin
            alu_res = diff;
            alu_ovf = (a_q[n-1] != b_q[n-1]) && (diff[n-1] != a_q[n-1]);
         end
         OpAnd:   alu_res = a_q & b_q;
         OpOr:    alu_res = a_q | b_q;
         OpSlt:   alu_res = {{(n-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   // Request outputs depend only on state and latched operands, so they hold
   // steady for the whole of a wait.
   always_comb begin
      state_d       = state_q;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state_q)
         StFetch: begin
            if (run_q) begin
               mem.mem_req  = 1'b1;
               mem.mem_addr = pc_q;
               if (mem.mem_ready) state_d = StDecode;
            end
         end
         StDecode: begin
            if (!legal || op == OpHalt) state_d = StHalt;
            else                        state_d = StExec;
         end
         StExec: begin
            if (is_rtype || op == OpAddi)       state_d = StWb;
            else if (op == OpLw || op == OpSw)  state_d = StMem;
            else                                state_d = StFetch;
         end
         StMem: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = alu_q;
            if (op == OpSw) begin
               mem.mem_we    = 1'b1;
               mem.mem_wdata = b_q;
            end
            if (mem.mem_ready) state_d = (op == OpLw) ? StWb : StFetch;
         end
         StWb:    state_d = StFetch;
         StHalt:  state_d = StHalt;
         default: state_d = StHalt;
      endcase
   end

   // run_q keeps mem_req low in the first cycle after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q <= 1'b0;
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         mdr_q <= '0;
         ovf_q <= 1'b0;
         ill_q <= 1'b0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            StFetch: begin
               if (run_q && mem.mem_ready) begin
                  ir_q <= mem.mem_rdata;
                  pc_q <= pc_q + 1'b1;
               end
            end
            StDecode: begin
               a_q <= rf_q[rs];
               b_q <= rf_q[rt];
               if (!legal) ill_q <= 1'b1;
            end
            StExec: begin
               alu_q <= alu_res;
               if (alu_ovf) ovf_q <= 1'b1;
               if (op == OpBeq && a_q == b_q) pc_q <= pc_q + imm;
               if (op == OpJ)                 pc_q <= target;
            end
            StMem: begin
               if (mem.mem_ready && op == OpLw) mdr_q <= mem.mem_rdata;
            end
            StWb: begin
               if (wb_dst != 3'd0) rf_q[wb_dst] <= wb_data;
            end
            default: ;
         endcase
      end
   end

endmodule
